// File: rtl/riscv_dtm_dmi_ctrl.sv
// riscv_dtm_dmi_ctrl: DTM-side DMI access controller; one outstanding DM request,
// sticky dmistat, dmireset/dtmhardreset handling and capture-DR response latching.
module riscv_dtm_dmi_ctrl #(
  parameter int ABITS     = 7,
  parameter int IDLE_HINT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmi_capture_i,
  input  logic        dmi_update_i,
  input  logic [40:0] dmi_wdata_i,
  output logic [40:0] dmi_rdata_o,
  input  logic        dtmcs_update_i,
  input  logic [31:0] dtmcs_wdata_i,
  output logic [31:0] dtmcs_rdata_o,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [40:0] req_o,
  input  logic        rsp_valid_i,
  output logic        rsp_ready_o,
  input  logic [31:0] rsp_data_i,
  input  logic [1:0]  rsp_op_i
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  state_e      state_q, state_d;
  logic [40:0] req_q, req_d;
  logic [6:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic [1:0]  sticky_q, sticky_d;
  logic        abort_q, abort_d;
  logic        dmi_upd, issue, accept, keep, clr, hard, busy_evt;
  logic        unused_bits;
  // A DTMCS write in the same cycle swallows the DMI update entirely.
  assign dmi_upd  = dmi_update_i && !dtmcs_update_i;
  assign issue    = state_q == IDLE && dmi_upd && sticky_q == 2'b00 &&
                    (dmi_wdata_i[1:0] == 2'b01 || dmi_wdata_i[1:0] == 2'b10);
  assign accept   = state_q == WAIT && rsp_valid_i;
  assign hard     = dtmcs_update_i && dtmcs_wdata_i[17];
  assign clr      = dtmcs_update_i && (dtmcs_wdata_i[16] || dtmcs_wdata_i[17]);
  assign keep     = accept && !abort_q && !hard;
  assign busy_evt = state_q != IDLE && (dmi_capture_i || dmi_upd);
  assign unused_bits = ^{dtmcs_wdata_i[31:18], dtmcs_wdata_i[15:0]};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE && issue)       ? REQ  :
              (state_q == REQ && req_ready_i) ? WAIT :
              accept                          ? IDLE : state_q;
  end
  always_comb begin
    req_valid_o = state_q == REQ;
    rsp_ready_o = state_q == WAIT;
  end
  // Clear beats any sticky set; a hard reset landing on the accepting cycle discards that response.
  always_comb begin
    req_d    = issue ? dmi_wdata_i : req_q;
    addr_d   = (state_q == IDLE && dmi_upd) ? dmi_wdata_i[40:34] : addr_q;
    data_d   = keep ? rsp_data_i : data_q;
    sticky_d = clr                     ? 2'b00    :
               sticky_q != 2'b00       ? sticky_q :
               busy_evt                ? 2'b11    :
               (keep && rsp_op_i[1])   ? rsp_op_i : 2'b00;
    abort_d  = !accept && (abort_q || (hard && state_q != IDLE));
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      sticky_q <= '0;
      abort_q  <= 1'b0;
    end else begin
      req_q    <= req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      sticky_q <= sticky_d;
      abort_q  <= abort_d;
    end
  end
  assign req_o         = req_q;
  assign dmi_rdata_o   = {addr_q, data_q, sticky_q != 2'b00 ? sticky_q :
                                          state_q != IDLE   ? 2'b11 : 2'b00};
  assign dtmcs_rdata_o = {17'b0, 3'(IDLE_HINT), sticky_q, 6'(ABITS), 4'd1};
endmodule
